phase_lock_monitor: RTL and testbench

Multi-channel, parametrised successor to the single-channel phase detector in the IAGC datapath. Each channel takes AXIS I/Q samples (I in the upper half, Q in the lower half of the word) and classifies each valid sample by quadrant against a run-time selectable reference quadrant. A per-channel lock state machine with separate lock and unlock hysteresis counts drives registered in-phase flags and lock/unlock event pulses. The block sits beside the IAGC controller and is gated by the IAGC status word.

---
 rtl/iagc_pkg.sv | 24 ++
 rtl/phase_lock_channel.sv | 121 ++++++++++++
 rtl/phase_lock_monitor.sv | 77 +++++++
 tb/tb_phase_lock_monitor.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/iagc_pkg.sv
// ---------------------------------------------------------------------------
// iagc_pkg
// Shared definitions for blocks that sit beside the IAGC controller:
//   - IAGC status word width and the two status codes decoded here
//   - lock-state enum used by the per-channel phase lock FSM
//   - small helper for sizing counters
// ---------------------------------------------------------------------------
package iagc_pkg;

  localparam int IAGC_STATUS_W = 4;

  localparam logic [IAGC_STATUS_W-1:0] IAGC_STATUS_RESET = 4'b0000;
  localparam logic [IAGC_STATUS_W-1:0] IAGC_STATUS_INIT  = 4'b0001;

  typedef enum logic {
    SEARCH = 1'b0,
    LOCKED = 1'b1
  } lock_state_e;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/phase_lock_channel.sv
// ---------------------------------------------------------------------------
// phase_lock_channel
// One I/Q channel: quadrant compare against the reference, SEARCH/LOCKED
// FSM with separate lock/unlock hysteresis counts, registered event pulses.
// Ports:
//   i_clock, i_reset_n  : clock, async active-low reset
//   i_clear             : synchronous return to SEARCH (IAGC status RESET)
//   i_enable            : samples are evaluated (IAGC status INIT)
//   i_sample, i_data    : sample strobe and I/Q word (I upper, Q lower half)
//   i_ref_quadrant      : reference {sign_I, sign_Q}
//   o_in_phase          : channel is LOCKED
//   o_lock_event        : one-cycle pulse on SEARCH->LOCKED
//   o_unlock_event      : one-cycle pulse on LOCKED->SEARCH
// ---------------------------------------------------------------------------
module phase_lock_channel
  import iagc_pkg::*;
#(
  parameter int AXIS_DATA_SIZE = 32,
  parameter int LOCK_COUNT     = 10,
  parameter int UNLOCK_COUNT   = 4
) (
  input  logic                      i_clock,
  input  logic                      i_reset_n,
  input  logic                      i_clear,
  input  logic                      i_enable,
  input  logic                      i_sample,
  input  logic [1:0]                i_ref_quadrant,
  input  logic [AXIS_DATA_SIZE-1:0] i_data,
  output logic                      o_in_phase,
  output logic                      o_lock_event,
  output logic                      o_unlock_event
);

  localparam int CNT_W = $clog2(max_int(LOCK_COUNT, UNLOCK_COUNT) + 1);
  localparam logic [CNT_W-1:0] LOCK_LAST   = CNT_W'(LOCK_COUNT - 1);
  localparam logic [CNT_W-1:0] UNLOCK_LAST = CNT_W'(UNLOCK_COUNT - 1);

  lock_state_e      state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             lock_event_q, lock_event_d;
  logic             unlock_event_q, unlock_event_d;
  logic [1:0]       quadrant;
  logic             match;

  // Only the two sign bits matter; the magnitudes are deliberately ignored.
  logic unused_data;
  assign unused_data = ^i_data;

  assign quadrant = {i_data[AXIS_DATA_SIZE-1], i_data[AXIS_DATA_SIZE/2-1]};
  assign match    = (quadrant == i_ref_quadrant);

  // State register.
  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge values of the others.
  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q        <= SEARCH;
      cnt_q          <= '0;
      lock_event_q   <= 1'b0;
      unlock_event_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      lock_event_q   <= lock_event_d;
      unlock_event_q <= unlock_event_d;
    end
  end

  // Next-state logic. The counter counts consecutive valid samples of the
  // kind that would cause a transition, and is cleared by the transition
  // itself, so it never reaches its wrap point.
  // NOTE: every signal gets a default first so no path leaves it unassigned,
  // which would otherwise infer a latch.
  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    lock_event_d   = 1'b0;
    unlock_event_d = 1'b0;
    if (i_clear) begin
      state_d = SEARCH;
      cnt_d   = '0;
    end else if (i_enable && i_sample) begin
      unique case (state_q)
        SEARCH: begin
          if (!match) begin
            cnt_d = '0;
          end else if (cnt_q == LOCK_LAST) begin
            state_d      = LOCKED;
            cnt_d        = '0;
            lock_event_d = 1'b1;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        LOCKED: begin
          if (match) begin
            cnt_d = '0;
          end else if (cnt_q == UNLOCK_LAST) begin
            state_d        = SEARCH;
            cnt_d          = '0;
            unlock_event_d = 1'b1;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        default: begin
          state_d = SEARCH;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // Outputs.
  always_comb begin
    o_in_phase     = (state_q == LOCKED);
    o_lock_event   = lock_event_q;
    o_unlock_event = unlock_event_q;
  end

endmodule

// File: rtl/phase_lock_monitor.sv
// ---------------------------------------------------------------------------
// phase_lock_monitor
// Multi-channel phase lock monitor gated by the IAGC status word.
// Ports:
//   i_clock, i_reset_n : clock, async active-low reset
//   i_iagc_status      : RESET clears all channels, INIT enables them,
//                        any other code freezes them
//   i_ref_quadrant     : reference quadrant {sign_I, sign_Q}
//   i_sample, i_data   : per-channel strobe; channel k at [k*W +: W]
//   o_in_phase         : per-channel lock flag
//   o_all_in_phase     : registered AND of o_in_phase (one cycle behind)
//   o_lock_event       : per-channel SEARCH->LOCKED pulse
//   o_unlock_event     : per-channel LOCKED->SEARCH pulse
// ---------------------------------------------------------------------------
module phase_lock_monitor
  import iagc_pkg::*;
#(
  parameter int N_CHANNELS       = 4,
  parameter int AXIS_DATA_SIZE   = 32,
  parameter int IAGC_STATUS_SIZE = IAGC_STATUS_W,
  parameter int LOCK_COUNT       = 10,
  parameter int UNLOCK_COUNT     = 4
) (
  input  logic                                 i_clock,
  input  logic                                 i_reset_n,
  input  logic [IAGC_STATUS_SIZE-1:0]          i_iagc_status,
  input  logic [1:0]                           i_ref_quadrant,
  input  logic [N_CHANNELS-1:0]                i_sample,
  input  logic [N_CHANNELS*AXIS_DATA_SIZE-1:0] i_data,
  output logic [N_CHANNELS-1:0]                o_in_phase,
  output logic                                 o_all_in_phase,
  output logic [N_CHANNELS-1:0]                o_lock_event,
  output logic [N_CHANNELS-1:0]                o_unlock_event
);

  logic status_reset;
  logic status_init;
  logic all_in_phase_q, all_in_phase_d;

  assign status_reset = (i_iagc_status == IAGC_STATUS_SIZE'(IAGC_STATUS_RESET));
  assign status_init  = (i_iagc_status == IAGC_STATUS_SIZE'(IAGC_STATUS_INIT));

  for (genvar k = 0; k < N_CHANNELS; k++) begin : g_channel
    phase_lock_channel #(
      .AXIS_DATA_SIZE(AXIS_DATA_SIZE),
      .LOCK_COUNT    (LOCK_COUNT),
      .UNLOCK_COUNT  (UNLOCK_COUNT)
    ) u_channel (
      .i_clock       (i_clock),
      .i_reset_n     (i_reset_n),
      .i_clear       (status_reset),
      .i_enable      (status_init),
      .i_sample      (i_sample[k]),
      .i_ref_quadrant(i_ref_quadrant),
      .i_data        (i_data[k*AXIS_DATA_SIZE +: AXIS_DATA_SIZE]),
      .o_in_phase    (o_in_phase[k]),
      .o_lock_event  (o_lock_event[k]),
      .o_unlock_event(o_unlock_event[k])
    );
  end

  // A RESET status also forces the aggregate flag low on the same edge.
  always_comb begin
    all_in_phase_d = status_reset ? 1'b0 : (&o_in_phase);
  end

  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      all_in_phase_q <= 1'b0;
    end else begin
      all_in_phase_q <= all_in_phase_d;
    end
  end

  assign o_all_in_phase = all_in_phase_q;

endmodule

// File: tb/tb_phase_lock_monitor.sv
// ---------------------------------------------------------------------------
// tb_phase_lock_monitor
// Directed and randomized stimulus for phase_lock_monitor, checked against a
// run-length reference model of the lock/unlock hysteresis rules.
// ---------------------------------------------------------------------------
module tb_phase_lock_monitor;

  localparam int N  = 4;
  localparam int W  = 32;
  localparam int SW = 4;
  localparam int LC = 10;
  localparam int UC = 4;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [SW-1:0]   status;
  logic [1:0]      ref_q;
  logic [N-1:0]    sample;
  logic [N*W-1:0]  data;
  logic [N-1:0]    in_phase;
  logic            all_in_phase;
  logic [N-1:0]    lock_ev;
  logic [N-1:0]    unlock_ev;

  always #5 clk = ~clk;

  phase_lock_monitor #(
    .N_CHANNELS      (N),
    .AXIS_DATA_SIZE  (W),
    .IAGC_STATUS_SIZE(SW),
    .LOCK_COUNT      (LC),
    .UNLOCK_COUNT    (UC)
  ) dut (
    .i_clock       (clk),
    .i_reset_n     (rst_n),
    .i_iagc_status (status),
    .i_ref_quadrant(ref_q),
    .i_sample      (sample),
    .i_data        (data),
    .o_in_phase    (in_phase),
    .o_all_in_phase(all_in_phase),
    .o_lock_event  (lock_ev),
    .o_unlock_event(unlock_ev)
  );

  // Reference model: run length of consecutive "transition-causing" samples.
  bit m_locked [N];
  int m_run    [N];
  bit m_lev    [N];
  bit m_uev    [N];
  bit m_all;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [N-1:0] pack(input bit v [N]);
    logic [N-1:0] r;
    for (int k = 0; k < N; k++) r[k] = v[k];
    return r;
  endfunction

  task automatic model_clear();
    for (int k = 0; k < N; k++) begin
      m_locked[k] = 0; m_run[k] = 0; m_lev[k] = 0; m_uev[k] = 0;
    end
    m_all = 0;
  endtask

  task automatic model_edge();
    bit all_now;
    bit match;
    all_now = 1;
    for (int k = 0; k < N; k++) all_now &= m_locked[k];
    if (!rst_n || status == 4'b0000) begin
      model_clear();
    end else begin
      m_all = all_now;
      for (int k = 0; k < N; k++) begin
        m_lev[k] = 0;
        m_uev[k] = 0;
        if (status == 4'b0001 && sample[k]) begin
          match = ({data[k*W+W-1], data[k*W+W/2-1]} == ref_q);
          if (!m_locked[k]) begin
            m_run[k] = match ? m_run[k] + 1 : 0;
            if (m_run[k] == LC) begin m_locked[k] = 1; m_run[k] = 0; m_lev[k] = 1; end
          end else begin
            m_run[k] = match ? 0 : m_run[k] + 1;
            if (m_run[k] == UC) begin m_locked[k] = 0; m_run[k] = 0; m_uev[k] = 1; end
          end
        end
      end
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, ".in_phase"},  32'(in_phase),     32'(pack(m_locked)));
    check({tag, ".lock_ev"},   32'(lock_ev),      32'(pack(m_lev)));
    check({tag, ".unlock_ev"}, 32'(unlock_ev),    32'(pack(m_uev)));
    check({tag, ".all"},       32'(all_in_phase), 32'(m_all));
  endtask

  // One clock: inputs are stable across the edge, outputs sampled 1ns later.
  task automatic tick(input string tag);
    @(posedge clk);
    model_edge();
    #1;
    check_all(tag);
  endtask

  function automatic logic [W-1:0] word_q(input logic [1:0] q);
    logic [W-1:0] w;
    w = W'($urandom);
    w[W-1]   = q[1];
    w[W/2-1] = q[0];
    return w;
  endfunction

  task automatic set_ch(input int k, input logic [1:0] q);
    data[k*W +: W] = word_q(q);
  endtask

  task automatic async_reset(input string tag);
    rst_n = 1'b0;
    #1;
    model_clear();
    check_all(tag);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n  = 1'b0;
    status = 4'b0000;
    ref_q  = 2'b00;
    sample = '1;
    data   = '0;
    model_clear();
    #12;
    check_all("por");
    rst_n = 1'b1;

    // Status RESET with all-zero data: nothing may lock.
    for (int i = 0; i < 50; i++) tick("gate_reset");

    // Async reset mid-count (cnt=6), then a full relock.
    status = 4'b0001;
    sample = 4'b0001;
    for (int i = 0; i < 6; i++) tick("pre_reset");
    async_reset("async_mid");
    for (int i = 0; i < 9; i++) tick("relock");
    check("relock_not_yet", 32'(in_phase[0]), 32'd0);
    tick("relock10");
    check("relock_lock", 32'(in_phase[0]), 32'd1);
    check("relock_event", 32'(lock_ev[0]), 32'd1);
    tick("relock_pulse_end");

    // Hysteresis: 3 mismatches + 1 match keep lock; 4 mismatches unlock.
    for (int i = 0; i < 3; i++) begin set_ch(0, 2'b10); tick("hyst_mis"); end
    set_ch(0, 2'b00); tick("hyst_match");
    check("hyst_held", 32'(in_phase[0]), 32'd1);
    for (int i = 0; i < 4; i++) begin set_ch(0, 2'b10); tick("hyst_unlock"); end
    check("unlock_flag", 32'(in_phase[0]), 32'd0);
    check("unlock_event", 32'(unlock_ev[0]), 32'd1);

    // 9 matches then one mismatch: no lock, count restarts.
    data = '0;
    for (int i = 0; i < 9; i++) tick("nine");
    set_ch(0, 2'b10); tick("break");
    data = '0;
    for (int i = 0; i < 9; i++) tick("restart");
    check("restart_no_lock", 32'(in_phase[0]), 32'd0);
    tick("restart_lock");

    // Quadrant mode: ref 11 locks, switching ref to 00 unlocks after 4.
    status = 4'b0000; tick("clear");
    status = 4'b0001; ref_q = 2'b11; sample = '1;
    for (int k = 0; k < N; k++) set_ch(k, 2'b11);
    for (int i = 0; i < 10; i++) tick("quad_lock");
    check("quad_locked", 32'(in_phase), 32'hF);
    ref_q = 2'b00;
    for (int i = 0; i < 4; i++) tick("quad_unlock");
    check("quad_unlocked", 32'(in_phase), 32'h0);

    // Sparse valid samples, then a freeze with status 0010 mid-count.
    data = '0;
    for (int c = 0; c < 30; c++) begin sample = (c % 3 == 2) ? '1 : '0; tick("sparse"); end
    check("sparse_lock", 32'(in_phase), 32'hF);
    status = 4'b0000; sample = '0; tick("clear2");
    status = 4'b0001; sample = '1;
    for (int i = 0; i < 5; i++) tick("frz_pre");
    status = 4'b0010;
    for (int i = 0; i < 8; i++) begin sample = 4'(($urandom)); set_ch(0, 2'b01); tick("frozen"); end
    data = '0; sample = '1; status = 4'b0001;
    for (int i = 0; i < 5; i++) tick("resume");
    check("resume_lock", 32'(in_phase), 32'hF);

    // Staggered multi-channel lock; aggregate lags the last channel.
    status = 4'b0000; tick("clear3");
    status = 4'b0001; data = '0;
    for (int c = 0; c < 22; c++) begin
      for (int k = 0; k < N; k++) sample[k] = (c >= 3 * k);
      tick("stagger");
    end

    // RESET status on the locking edge suppresses the lock event.
    status = 4'b0000; tick("clear4");
    status = 4'b0001; sample = 4'b0001;
    for (int i = 0; i < 9; i++) tick("almost");
    status = 4'b0000; tick("reset_wins");
    check("reset_wins_ev", 32'(lock_ev[0]), 32'd0);

    // Randomized traffic, matches biased toward the reference.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 99) < 2) ref_q = 2'($urandom);
      case ($urandom_range(0, 99)) inside
        [0:1]:   status = 4'b0000;
        [2:5]:   status = SW'($urandom_range(2, 15));
        default: status = 4'b0001;
      endcase
      sample = N'($urandom);
      for (int k = 0; k < N; k++)
        set_ch(k, ($urandom_range(0, 9) < 8) ? ref_q : 2'($urandom));
      if ($urandom_range(0, 999) == 0) async_reset("rand_async");
      tick("random");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
